// File: rtl/vram_write_scheduler.sv
// VRAM write scheduler: queues CPU writes until the video write window opens,
// and runs a nametable fill engine that yields to queued CPU writes.
`timescale 1ns/1ps

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_write_scheduler #(
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter int DEPTH = 16,
    parameter logic [ADDR_WIDTH-1:0] NTBL_BASE = 'h400,
    parameter int NTBL_TILES = 960
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writable,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [7:0]            in_data,
    input  logic                  in_we,
    input  logic                  fill_start,
    input  logic [7:0]            fill_value,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [7:0]            out_data,
    output logic                  out_we,
    output logic                  full,
    output logic                  busy,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = ADDR_WIDTH + 8;
    localparam logic [9:0] LAST_TILE = 10'(NTBL_TILES - 1);

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    fill_state_t state;
    logic [9:0] fill_cnt;
    logic [7:0] fill_reg;

    logic [EW-1:0] mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [EW-1:0] head;

    logic empty;
    logic is_full;
    logic pop;
    logic push;
    logic fill_issue;
    logic fill_last;

    // Full/empty are told apart by the pointer MSB.
    assign empty = (wr_ptr == rd_ptr);
    assign is_full = (wr_ptr[PW] != rd_ptr[PW]) &&
                     (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign head = mem[rd_ptr[PW-1:0]];

    assign pop = writable && !empty;
    assign push = in_we && (!is_full || pop);
    assign fill_issue = writable && empty && (state == FILL);
    assign fill_last = fill_issue && (fill_cnt == LAST_TILE);

    assign full = is_full;
    assign busy = !empty || (state == FILL);
    assign fill_busy = (state == FILL);

    always_comb begin
        out_we = 1'b0;
        out_addr = '0;
        out_data = '0;
        if (pop) begin
            out_we = 1'b1;
            out_addr = head[EW-1:8];
            out_data = head[7:0];
        end else if (fill_issue) begin
            out_we = 1'b1;
            out_addr = NTBL_BASE + ADDR_WIDTH'(fill_cnt);
            out_data = fill_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_we && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fill_cnt <= '0;
            fill_reg <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= fill_last;
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        state <= FILL;
                        fill_cnt <= '0;
                        fill_reg <= fill_value;
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        state <= IDLE;
                    end else if (fill_issue) begin
                        fill_cnt <= fill_cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Self-checking bench for vram_write_scheduler: directed table, corner
// sequences and random traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_vram_write_scheduler;

    localparam int DEPTH = 16;
    localparam int TILES = 960;
    localparam logic [11:0] BASE = 12'h400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic writable = 1'b0;
    logic [11:0] in_addr = '0;
    logic [7:0] in_data = '0;
    logic in_we = 1'b0;
    logic fill_start = 1'b0;
    logic [7:0] fill_value = '0;
    logic [11:0] out_addr;
    logic [7:0] out_data;
    logic out_we;
    logic full;
    logic busy;
    logic fill_busy;
    logic fill_done;
    logic overflow;

    vram_write_scheduler dut (
        .clk(clk),
        .rst(rst),
        .writable(writable),
        .in_addr(in_addr),
        .in_data(in_data),
        .in_we(in_we),
        .fill_start(fill_start),
        .fill_value(fill_value),
        .out_addr(out_addr),
        .out_data(out_data),
        .out_we(out_we),
        .full(full),
        .busy(busy),
        .fill_busy(fill_busy),
        .fill_done(fill_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        bit w;
        bit we;
        logic [11:0] a;
        logic [7:0] d;
        bit e_we;
        logic [11:0] e_a;
        logic [7:0] e_d;
        bit e_busy;
    } vec_t;

    // Reference model: pending writes in a queue, fill as a counter.
    wr_t q[$];
    bit m_fill;
    bit m_done;
    bit m_ovf;
    int m_cnt;
    logic [7:0] m_val;

    int n_chk = 0;
    int n_fail = 0;
    int wcnt [4096];
    logic [7:0] wval [4096];
    int done_pulses = 0;

    logic obs_we;
    logic [11:0] obs_addr;
    logic [7:0] obs_data;
    logic obs_busy;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fill = 0;
        m_done = 0;
        m_ovf = 0;
        m_cnt = 0;
        m_val = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs",
              32'({out_we, out_addr, out_data, full, busy, fill_busy,
                   fill_done, overflow}), 32'd0);
        model_reset();
        writable = 1'b0;
        in_we = 1'b0;
        fill_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cycle(input bit w, input bit we, input logic [11:0] a,
                         input logic [7:0] d, input bit fs,
                         input logic [7:0] fv);
        logic [24:0] exp_v;
        logic [24:0] act_v;
        bit e_we;
        logic [11:0] e_a;
        logic [7:0] e_d;
        bit pop;
        bit fiss;
        int sz;
        wr_t e;
        writable = w;
        in_we = we;
        in_addr = a;
        in_data = d;
        fill_start = fs;
        fill_value = fv;
        #1;
        sz = q.size();
        e_we = 0;
        e_a = '0;
        e_d = '0;
        if (w && sz > 0) begin
            e_we = 1;
            e_a = q[0].a;
            e_d = q[0].d;
        end else if (w && m_fill) begin
            e_we = 1;
            e_a = BASE + 12'(m_cnt);
            e_d = m_val;
        end
        exp_v = {e_we, e_a, e_d, sz == DEPTH, (sz > 0) || m_fill, m_fill,
                 m_done, m_ovf};
        act_v = {out_we, out_addr, out_data, full, busy, fill_busy,
                 fill_done, overflow};
        check("cycle_outputs", 32'(act_v), 32'(exp_v));
        obs_we = out_we;
        obs_addr = out_addr;
        obs_data = out_data;
        obs_busy = busy;
        if (out_we === 1'b1) begin
            wcnt[out_addr]++;
            wval[out_addr] = out_data;
        end
        if (fill_done === 1'b1) done_pulses++;
        @(posedge clk);
        pop = w && sz > 0;
        fiss = w && sz == 0 && m_fill;
        m_done = fiss && m_cnt == TILES - 1;
        if (pop) void'(q.pop_front());
        if (we) begin
            if (sz < DEPTH || pop) begin
                e.a = a;
                e.d = d;
                q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
        if (fiss) begin
            if (m_cnt == TILES - 1) m_fill = 0;
            else m_cnt++;
        end else if (!m_fill && fs) begin
            m_fill = 1;
            m_cnt = 0;
            m_val = fv;
        end
        #1;
    endtask

    task automatic idle_cycle(input bit w);
        cycle(w, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int wp;

        tbl[0] = '{0, 1, 12'h205, 8'h11, 0, 12'h000, 8'h00, 0};
        tbl[1] = '{0, 1, 12'h206, 8'h22, 0, 12'h000, 8'h00, 1};
        tbl[2] = '{0, 1, 12'h410, 8'h33, 0, 12'h000, 8'h00, 1};
        tbl[3] = '{1, 0, 12'h000, 8'h00, 1, 12'h205, 8'h11, 1};
        tbl[4] = '{1, 0, 12'h000, 8'h00, 1, 12'h206, 8'h22, 1};
        tbl[5] = '{1, 0, 12'h000, 8'h00, 1, 12'h410, 8'h33, 1};
        tbl[6] = '{1, 0, 12'h000, 8'h00, 0, 12'h000, 8'h00, 0};
        tbl[7] = '{0, 0, 12'h000, 8'h00, 0, 12'h000, 8'h00, 0};

        #2;
        do_reset();

        // Basic drain
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].w, tbl[i].we, tbl[i].a, tbl[i].d, 1'b0, 8'h00);
            check("drain_vec",
                  32'({obs_we, obs_addr, obs_data, obs_busy}),
                  32'({tbl[i].e_we, tbl[i].e_a, tbl[i].e_d, tbl[i].e_busy}));
        end

        // Overflow
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 12'h100 + 12'(i), 8'(i), 1'b0, 8'h00);
            if (i == DEPTH - 1) check("ovf_full_at_depth", 32'(full), 32'd1);
            if (i == DEPTH - 1) check("ovf_clear_at_depth", 32'(overflow), 32'd0);
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            idle_cycle(1'b1);
            if (obs_we === 1'b1) n++;
        end
        check("ovf_drain_count", 32'(n), 32'(DEPTH));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full push/pop
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 1'b1, 12'h300 + 12'(i), 8'(i), 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 12'h380 + 12'(i), 8'(8'h40 + i), 1'b0, 8'h00);
            check("fpp_full_noovf", 32'({full, overflow}), 32'b10);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle_cycle(1'b1);

        // Fill with pauses
        do_reset();
        for (int a = 0; a < 4096; a++) wcnt[a] = 0;
        done_pulses = 0;
        for (int i = 0; i < 1930; i++)
            cycle((i % 2) == 1, 1'b0, 12'h000, 8'h00, i == 0, 8'h80);
        bad = 0;
        for (int a = 'h400; a < 'h7C0; a++)
            if (wcnt[a] != 1 || wval[a] !== 8'h80) bad++;
        check("fill_cover_bad", 32'(bad), 32'd0);
        check("fill_tail_untouched", 32'(wcnt['h7C0]), 32'd0);
        check("fill_done_pulses", 32'(done_pulses), 32'd1);
        check("fill_busy_end", 32'(fill_busy), 32'd0);

        // Fill with CPU priority
        do_reset();
        done_pulses = 0;
        cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h55);
        for (int i = 0; i < 10; i++) idle_cycle(1'b1);
        check("prio_pre", 32'({obs_we, obs_addr, obs_data}),
              32'({1'b1, 12'h409, 8'h55}));
        cycle(1'b0, 1'b1, 12'h500, 8'h07, 1'b0, 8'h00);
        idle_cycle(1'b1);
        check("prio_cpu", 32'({obs_we, obs_addr, obs_data}),
              32'({1'b1, 12'h500, 8'h07}));
        idle_cycle(1'b1);
        check("prio_resume", 32'({obs_we, obs_addr, obs_data}),
              32'({1'b1, 12'h40A, 8'h55}));
        for (int i = 0; i < 1000; i++) begin
            if (fill_busy !== 1'b1) break;
            idle_cycle(1'b1);
        end
        check("prio_fill_ended", 32'(fill_busy), 32'd0);
        idle_cycle(1'b1);
        check("prio_done_pulses", 32'(done_pulses), 32'd1);

        // Async reset mid-fill with entries queued
        do_reset();
        done_pulses = 0;
        cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 8'h3C);
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 12'h600 + 12'(i), 8'(i), 1'b0, 8'h00);
        writable = 1'b1;
        #1;
        check("pre_rst_we", 32'({out_we, out_addr}), 32'({1'b1, 12'h600}));
        do_reset();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            idle_cycle(1'b1);
            if (obs_we === 1'b1) n++;
        end
        check("post_rst_no_we", 32'(n), 32'd0);
        check("post_rst_no_done", 32'(done_pulses), 32'd0);

        // Random traffic against the model
        do_reset();
        wp = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) wp = $urandom_range(0, 4);
            cycle($urandom_range(0, 3) < wp, $urandom_range(0, 2) == 0,
                  12'($urandom), 8'($urandom), $urandom_range(0, 299) == 0,
                  8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
